// File: rtl/muldiv_unit.sv
//------------------------------------------------------------------------------
// Module   : muldiv_unit
// Function : Iterative one-bit-per-clock mult/multu/div/divu engine writing hi/lo.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] gr1,
  input  logic [WIDTH-1:0] gr2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] c_LAST = CNT_W'(WIDTH - 1);

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_div;
  logic               r_zero;
  logic               r_neg_lo;
  logic               r_neg_hi;
  logic [WIDTH-1:0]   r_opnd;
  logic [WIDTH-1:0]   r_gr1;
  logic [2*WIDTH-1:0] r_acc;
  logic               r_busy;
  logic               r_done;
  logic               r_dbz;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  logic               w_signed;
  logic [WIDTH-1:0]   w_a_abs;
  logic [WIDTH-1:0]   w_b_abs;
  logic [WIDTH:0]     w_madd;
  logic [WIDTH+1:0]   w_dsub;
  logic [2*WIDTH-1:0] w_prod_neg;

  assign w_signed   = ~op[0];
  assign w_a_abs    = (w_signed && gr1[WIDTH-1]) ? (-gr1) : gr1;
  assign w_b_abs    = (w_signed && gr2[WIDTH-1]) ? (-gr2) : gr2;
  // Multiply: add the multiplicand into the upper half when the low bit of the multiplier is set.
  assign w_madd     = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
  // Divide: trial-subtract the divisor from {remainder, next dividend bit}; bit WIDTH+1 is the borrow.
  assign w_dsub     = {1'b0, r_acc[2*WIDTH-1:WIDTH-1]} - {2'b00, r_opnd};
  assign w_prod_neg = -r_acc;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_div    <= 1'b0;
      r_zero   <= 1'b0;
      r_neg_lo <= 1'b0;
      r_neg_hi <= 1'b0;
      r_opnd   <= '0;
      r_gr1    <= '0;
      r_acc    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_dbz    <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          r_done <= 1'b0;
          if (start) begin
            r_state  <= S_CALC;
            r_cnt    <= '0;
            r_busy   <= 1'b1;
            r_dbz    <= 1'b0;
            r_div    <= op[1];
            r_zero   <= op[1] && (gr2 == '0);
            r_neg_lo <= w_signed && (gr1[WIDTH-1] ^ gr2[WIDTH-1]);
            r_neg_hi <= w_signed && op[1] && gr1[WIDTH-1];
            r_gr1    <= gr1;
            r_opnd   <= op[1] ? w_b_abs : w_a_abs;
            r_acc    <= op[1] ? {{WIDTH{1'b0}}, w_a_abs} : {{WIDTH{1'b0}}, w_b_abs};
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_CALC: begin
          if (r_div) begin
            if (!w_dsub[WIDTH+1])
              r_acc <= {w_dsub[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
            else
              r_acc <= {r_acc[2*WIDTH-2:0], 1'b0};
          end else begin
            r_acc <= {w_madd, r_acc[WIDTH-1:1]};
          end
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == c_LAST)
            r_state <= S_FIX;
        end
        S_FIX: begin
          if (!r_div) begin
            {r_hi, r_lo} <= r_neg_lo ? w_prod_neg : r_acc;
          end else if (r_zero) begin
            r_lo <= '1;
            r_hi <= r_gr1;
          end else begin
            r_lo <= r_neg_lo ? (-r_acc[WIDTH-1:0]) : r_acc[WIDTH-1:0];
            r_hi <= r_neg_hi ? (-r_acc[2*WIDTH-1:WIDTH]) : r_acc[2*WIDTH-1:WIDTH];
          end
          r_dbz   <= r_zero;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_DONE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign hi          = r_hi;
  assign lo          = r_lo;
  assign div_by_zero = r_dbz;

endmodule

`default_nettype wire

// File: tb/tb_muldiv_unit.sv
//------------------------------------------------------------------------------
// Module   : tb_muldiv_unit
// Function : Scoreboard bench for muldiv_unit using directed hand-computed vectors.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] gr1 = '0;
  logic [31:0] gr2 = '0;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        div_by_zero;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
    int          cyc;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;

  localparam logic [1:0] c_MULT = 2'b00, c_MULTU = 2'b01, c_DIV = 2'b10, c_DIVU = 2'b11;

  muldiv_unit #(.WIDTH(32), .CNT_W(5)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .gr1(gr1), .gr2(gr2),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: pops one expectation per done pulse.
  always @(negedge clk) begin
    if (!reset && done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check({e.name, ".hi"}, {32'd0, hi}, {32'd0, e.hi});
        check({e.name, ".lo"}, {32'd0, lo}, {32'd0, e.lo});
        check({e.name, ".dbz"}, {63'd0, div_by_zero}, {63'd0, e.dbz});
        check({e.name, ".latency"}, 64'(cyc), 64'(e.cyc));
      end
    end
  end

  // Caller is positioned at a negedge; start is held for exactly one rising edge.
  task automatic issue(input string name, input logic [1:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic expect_done,
                       input logic [31:0] eh, input logic [31:0] el, input logic ed);
    exp_t e;
    start = 1'b1; op = o; gr1 = a; gr2 = b;
    if (expect_done) begin
      e.hi = eh; e.lo = el; e.dbz = ed; e.cyc = cyc + 34; e.name = name;
      exp_q.push_back(e);
    end
    @(negedge clk);
    start = 1'b0; op = 2'($urandom); gr1 = $urandom; gr2 = $urandom;
  endtask

  task automatic wait_done(input string name);
    int k;
    for (k = 0; k < 50 && !done; k++) @(negedge clk);
    if (!done) check({name, ".timeout"}, 64'd1, 64'd0);
  endtask

  task automatic run(input string name, input logic [1:0] o, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                     input logic ed);
    @(negedge clk);
    issue(name, o, a, b, 1'b1, eh, el, ed);
    wait_done(name);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst.busy", {63'd0, busy}, 64'd0);
    check("rst.done", {63'd0, done}, 64'd0);
    check("rst.hilo", {hi, lo}, 64'd0);
    check("rst.dbz", {63'd0, div_by_zero}, 64'd0);
    reset = 1'b0;

    run("mult_neg7", c_MULT, 32'hFFFFFFF9, 32'h00000001, 32'hFFFFFFFF, 32'hFFFFFFF9, 1'b0);
    run("mult_big", c_MULT, 32'h80000013, 32'h80000001, 32'h3FFFFFF6, 32'h00000013, 1'b0);
    run("multu_big", c_MULTU, 32'h80000013, 32'h80000001, 32'h4000000A, 32'h00000013, 1'b0);
    run("mult_5xm3", c_MULT, 32'd5, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0);
    run("div_19_5", c_DIV, 32'd19, 32'd5, 32'd4, 32'd3, 1'b0);
    run("div_m21_5", c_DIV, 32'hFFFFFFEB, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFFC, 1'b0);
    run("div_19_m5", c_DIV, 32'd19, 32'hFFFFFFFB, 32'd4, 32'hFFFFFFFD, 1'b0);
    run("divu_big", c_DIVU, 32'h80000013, 32'h80000001, 32'h00000012, 32'h00000001, 1'b0);
    run("div_ovf", c_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0);
    run("div_zero", c_DIV, 32'h00001234, 32'd0, 32'h00001234, 32'hFFFFFFFF, 1'b1);
    run("divu_zero", c_DIVU, 32'h00001234, 32'd0, 32'h00001234, 32'hFFFFFFFF, 1'b1);

    // Flag must clear at the next accepted start.
    @(negedge clk);
    issue("dbz_clear_op", c_MULTU, 32'd3, 32'd4, 1'b1, 32'd0, 32'd12, 1'b0);
    check("dbz_cleared", {63'd0, div_by_zero}, 64'd0);
    check("busy_after_start", {63'd0, busy}, 64'd1);
    wait_done("dbz_clear_op");

    // Start while busy is ignored; start during DONE is accepted back-to-back.
    @(negedge clk);
    issue("multu_7x1", c_MULTU, 32'd7, 32'd1, 1'b1, 32'd0, 32'd7, 1'b0);
    repeat (3) @(negedge clk);
    issue("ignored", c_MULTU, 32'h12345678, 32'h9ABCDEF0, 1'b0, 32'd0, 32'd0, 1'b0);
    wait_done("multu_7x1");
    issue("b2b_div", c_DIVU, 32'd100, 32'd7, 1'b1, 32'd2, 32'd14, 1'b0);
    check("b2b_busy", {63'd0, busy}, 64'd1);
    wait_done("b2b_div");

    // Reset mid-operation discards the result.
    @(negedge clk);
    issue("aborted", c_MULTU, 32'd9, 32'd9, 1'b0, 32'd0, 32'd0, 1'b0);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midrst.busy", {63'd0, busy}, 64'd0);
    check("midrst.hilo", {hi, lo}, 64'd0);
    check("midrst.done", {63'd0, done}, 64'd0);
    reset = 1'b0;
    repeat (45) @(negedge clk);

    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
